// File: rtl/vector_sequencer_pkg.sv
// rtl/vector_sequencer_pkg.sv - shared processor constants, FSM states and ALU classes
package vector_sequencer_pkg;

    // Major opcode the control decoder uses to flag a vector instruction
    localparam logic [6:0] OPCODE_VECTOR = 7'b0100111;

    // ALU class encodings carried on alu_op / elem_alu_op
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_LOGIC = 2'b10;
    localparam logic [1:0] ALU_SHIFT = 2'b11;

    // Vector sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Decoder helper: true when the opcode selects the vector unit
    function automatic logic is_vector_opcode(input logic [6:0] opcode);
        return opcode == OPCODE_VECTOR;
    endfunction

endpackage

// File: rtl/vector_sequencer_elem_counter.sv
// rtl/vector_sequencer_elem_counter.sv - element index counter with last-element compare
module vector_sequencer_elem_counter
    import vector_sequencer_pkg::*;
#(
    parameter int NUM_ELEMS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LAST_IDX);

    // Next index: clear wins, and stepping past the last element returns to 0
    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            if (last_o) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - issues NUM_ELEMS element operations per vector instruction
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int NUM_ELEMS = 4,
    parameter int REG_IDX_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [1:0]                   alu_op,
    input  logic                         reg_write,
    input  logic [REG_IDX_W-1:0]         vs1,
    input  logic [REG_IDX_W-1:0]         vs2,
    input  logic [REG_IDX_W-1:0]         vd,
    input  logic                         flush,
    output logic                         elem_valid,
    input  logic                         elem_ready,
    output logic [$clog2(NUM_ELEMS)-1:0] elem_idx,
    output logic [1:0]                   elem_alu_op,
    output logic                         elem_we,
    output logic [REG_IDX_W-1:0]         elem_vs1,
    output logic [REG_IDX_W-1:0]         elem_vs2,
    output logic [REG_IDX_W-1:0]         elem_vd,
    output logic                         elem_last,
    output logic                         stall,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_ELEMS);

    seq_state_e state_q;
    seq_state_e state_d;

    logic                 capture_en;
    logic                 idx_clear;
    logic                 idx_inc;
    logic [IDX_W-1:0]     idx;
    logic                 idx_last;

    logic [1:0]           alu_op_q;
    logic                 we_q;
    logic [REG_IDX_W-1:0] vs1_q;
    logic [REG_IDX_W-1:0] vs2_q;
    logic [REG_IDX_W-1:0] vd_q;

    vector_sequencer_elem_counter #(
        .NUM_ELEMS (NUM_ELEMS),
        .IDX_W     (IDX_W)
    ) u_elem_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (idx_clear),
        .inc_i   (idx_inc),
        .idx_o   (idx),
        .last_o  (idx_last)
    );

    // Next state and counter control; flush overrides everything, including a same-cycle issue
    always_comb begin
        state_d    = state_q;
        capture_en = 1'b0;
        idx_clear  = 1'b0;
        idx_inc    = 1'b0;
        if (flush) begin
            state_d   = ST_IDLE;
            idx_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_valid) begin
                        capture_en = 1'b1;
                        idx_clear  = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (elem_ready) begin
                        idx_inc = 1'b1;
                        if (idx_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    idx_clear = 1'b1;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction fields, loaded only on accept so element outputs never track the inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= '0;
            we_q     <= 1'b0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
        end else if (capture_en) begin
            alu_op_q <= alu_op;
            we_q     <= reg_write;
            vs1_q    <= vs1;
            vs2_q    <= vs2;
            vd_q     <= vd;
        end
    end

    assign issue_ready = (state_q == ST_IDLE);
    assign elem_valid  = (state_q == ST_RUN);
    assign stall       = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE) && !flush;

    assign elem_idx    = idx;
    assign elem_last   = idx_last;
    assign elem_alu_op = alu_op_q;
    assign elem_we     = we_q;

    // Register indices wrap modulo 2^REG_IDX_W by construction of the adder width
    assign elem_vs1 = vs1_q + REG_IDX_W'(idx);
    assign elem_vs2 = vs2_q + REG_IDX_W'(idx);
    assign elem_vd  = vd_q + REG_IDX_W'(idx);

endmodule

// File: tb/tb_vector_sequencer.sv
// tb/tb_vector_sequencer.sv - self-checking bench for vector_sequencer
module tb_vector_sequencer;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [1:0]    alu_op;
    logic          reg_write;
    logic [RW-1:0] vs1;
    logic [RW-1:0] vs2;
    logic [RW-1:0] vd;
    logic          flush;
    logic          elem_valid;
    logic          elem_ready;
    logic [IW-1:0] elem_idx;
    logic [1:0]    elem_alu_op;
    logic          elem_we;
    logic [RW-1:0] elem_vs1;
    logic [RW-1:0] elem_vs2;
    logic [RW-1:0] elem_vd;
    logic          elem_last;
    logic          stall;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    vector_sequencer #(.NUM_ELEMS(N), .REG_IDX_W(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .vs1         (vs1),
        .vs2         (vs2),
        .vd          (vd),
        .flush       (flush),
        .elem_valid  (elem_valid),
        .elem_ready  (elem_ready),
        .elem_idx    (elem_idx),
        .elem_alu_op (elem_alu_op),
        .elem_we     (elem_we),
        .elem_vs1    (elem_vs1),
        .elem_vs2    (elem_vs2),
        .elem_vd     (elem_vd),
        .elem_last   (elem_last),
        .stall       (stall),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending element operations plus a pending done pulse
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [RW-1:0] vs1;
        logic [RW-1:0] vs2;
        logic [RW-1:0] vd;
        logic [1:0]    op;
        logic          we;
    } op_t;

    op_t m_ops[$];
    bit  m_done_due;

    task automatic model_reset();
        m_ops.delete();
        m_done_due = 1'b0;
    endtask

    task automatic model_edge();
        op_t o;
        if (flush) begin
            model_reset();
        end else if (m_ops.size() > 0) begin
            if (elem_ready) begin
                o = m_ops.pop_front();
                if (m_ops.size() == 0) m_done_due = 1'b1;
            end
        end else if (m_done_due) begin
            m_done_due = 1'b0;
        end else if (issue_valid) begin
            for (int i = 0; i < N; i++) begin
                o.idx = IW'(i);
                o.vs1 = RW'((int'(vs1) + i) % (1 << RW));
                o.vs2 = RW'((int'(vs2) + i) % (1 << RW));
                o.vd  = RW'((int'(vd) + i) % (1 << RW));
                o.op  = alu_op;
                o.we  = reg_write;
                m_ops.push_back(o);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        flush       = 1'b0;
        elem_ready  = 1'b0;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        vs1         = '0;
        vs2         = '0;
        vd          = '0;
    endtask

    task automatic drain();
        int c;
        issue_valid = 1'b0;
        elem_ready  = 1'b1;
        c = 0;
        while (stall && c < 40) begin
            cyc();
            c++;
        end
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: stall=%0b after %0d cycles, required 0", stall, c);
        end
        elem_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({elem_valid, done, stall, issue_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/done/stall/ready=%b required 0001",
                     {elem_valid, done, stall, issue_ready});
        end
        n_tests++;
        if ({elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: idx=%0d vs1=%0d vs2=%0d vd=%0d op=%0d we=%0b required all 0",
                     elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        idle_inputs();
        alu_op = 2'b01; reg_write = 1'b1; vs1 = 5'd2; vs2 = 5'd8; vd = 5'd16;
        issue_valid = 1'b1;
        elem_ready  = 1'b1;
        n_tests++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: issue_ready=%0b required 1", issue_ready);
        end
        cyc();
        issue_valid = 1'b0;
        alu_op = 2'b10; reg_write = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({elem_valid, elem_last, done, stall, issue_ready} !== {1'b1, (k == N - 1), 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_ctrl[%0d]: valid/last/done/stall/ready=%b", k,
                         {elem_valid, elem_last, done, stall, issue_ready});
            end
            n_tests++;
            if ({elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we} !==
                {IW'(k), RW'(2 + k), RW'(8 + k), RW'(16 + k), 2'b01, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_fields[%0d]: idx=%0d vs1=%0d vs2=%0d vd=%0d op=%0d we=%0b required %0d %0d %0d %0d 1 1",
                         k, elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we,
                         k, 2 + k, 8 + k, 16 + k);
            end
            cyc();
        end
        n_tests++;
        if ({done, elem_valid, stall, issue_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_done: done/valid/stall/ready=%b required 1010",
                     {done, elem_valid, stall, issue_ready});
        end
        cyc();
        n_tests++;
        if ({done, stall, issue_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_after_done: done/stall/ready=%b required 001", {done, stall, issue_ready});
        end
        elem_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [6:0]  pat;
        logic [31:0] snap;
        logic        r;
        int          hs;
        int          c;
        bit          seen_done;
        pat = 7'b1011001;
        idle_inputs();
        alu_op = 2'($urandom); reg_write = 1'($urandom);
        vs1 = RW'($urandom); vs2 = RW'($urandom); vd = RW'($urandom);
        issue_valid = 1'b1;
        cyc();
        issue_valid = 1'b0;
        hs = 0;
        c = 0;
        seen_done = 1'b0;
        while (!seen_done && c < 20) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                r = (c < 7) ? pat[c] : 1'b1;
                elem_ready = r;
                snap = 32'({elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we, elem_last, elem_valid});
                n_tests++;
                if (elem_idx !== IW'(hs)) begin
                    n_fail++;
                    $display("FAIL stall_idx[%0d]: elem_idx=%0d required %0d", c, elem_idx, hs);
                end
                if (elem_valid && r) hs++;
                cyc();
                if (!r) begin
                    n_tests++;
                    if (32'({elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we, elem_last, elem_valid}) !== snap) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: outputs %h required %h", c,
                                 32'({elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we, elem_last, elem_valid}), snap);
                    end
                end
                c++;
            end
        end
        n_tests++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL stall_done_timeout: done=0 after %0d cycles, required 1", c);
        end
        n_tests++;
        if (hs != N || c != 7) begin
            n_fail++;
            $display("FAIL stall_handshakes: %0d handshakes in %0d cycles, required %0d in 7", hs, c, N);
        end
        drain();
    endtask

    task automatic test_wrap();
        idle_inputs();
        vd = 5'd30; vs1 = 5'd31; vs2 = RW'($urandom);
        issue_valid = 1'b1;
        elem_ready  = 1'b1;
        cyc();
        issue_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({elem_vd, elem_vs1} !== {RW'((30 + k) % 32), RW'((31 + k) % 32)}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: elem_vd=%0d elem_vs1=%0d required %0d %0d",
                         k, elem_vd, elem_vs1, (30 + k) % 32, (31 + k) % 32);
            end
            cyc();
        end
        drain();
    endtask

    task automatic test_flush();
        idle_inputs();
        vd = 5'd12; vs1 = 5'd1; vs2 = 5'd3;
        issue_valid = 1'b1;
        elem_ready  = 1'b1;
        cyc();
        issue_valid = 1'b0;
        cyc();
        cyc();
        n_tests++;
        if ({elem_valid, elem_idx} !== {1'b1, IW'(2)}) begin
            n_fail++;
            $display("FAIL flush_pre: valid=%0b idx=%0d required 1 2", elem_valid, elem_idx);
        end
        flush = 1'b1;
        issue_valid = 1'b1; vd = 5'd5;
        cyc();
        flush = 1'b0;
        #1;
        n_tests++;
        if ({elem_valid, stall, done, issue_ready, elem_idx} !== {4'b0001, IW'(0)}) begin
            n_fail++;
            $display("FAIL flush_idle: valid/stall/done/ready=%b idx=%0d required 0001 0",
                     {elem_valid, stall, done, issue_ready}, elem_idx);
        end
        vd = 5'd9;
        cyc();
        issue_valid = 1'b0;
        n_tests++;
        if ({elem_valid, elem_vd, elem_idx} !== {1'b1, RW'(9), IW'(0)}) begin
            n_fail++;
            $display("FAIL flush_reissue: valid=%0b vd=%0d idx=%0d required 1 9 0", elem_valid, elem_vd, elem_idx);
        end
        drain();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        vd = 5'd20;
        issue_valid = 1'b1;
        elem_ready  = 1'b1;
        cyc();
        issue_valid = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({elem_valid, stall, done, issue_ready, elem_idx, elem_vd} !== {4'b0001, IW'(0), RW'(0)}) begin
            n_fail++;
            $display("FAIL async_reset: valid/stall/done/ready=%b idx=%0d vd=%0d required 0001 0 0",
                     {elem_valid, stall, done, issue_ready}, elem_idx, elem_vd);
        end
        cyc();
        n_tests++;
        if ({done, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_nodone: done/stall=%b required 00", {done, stall});
        end
        rst_n = 1'b1;
        vd = 5'd7;
        issue_valid = 1'b1;
        cyc();
        issue_valid = 1'b0;
        n_tests++;
        if ({elem_valid, elem_vd} !== {1'b1, RW'(7)}) begin
            n_fail++;
            $display("FAIL async_reset_first_accept: valid=%0b vd=%0d required 1 7", elem_valid, elem_vd);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        vd = 5'd3; vs1 = 5'd4; vs2 = 5'd5; alu_op = 2'b10; reg_write = 1'b0;
        issue_valid = 1'b1;
        elem_ready  = 1'b1;
        cyc();
        vd = 5'd20; vs1 = 5'd21; vs2 = 5'd22; alu_op = 2'b11; reg_write = 1'b1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if ({elem_valid, elem_vd, elem_vs1, elem_alu_op, elem_we} !==
                {1'b1, RW'(3 + k), RW'(4 + k), 2'b10, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_first[%0d]: valid=%0b vd=%0d vs1=%0d op=%0d we=%0b required 1 %0d %0d 2 0",
                         k, elem_valid, elem_vd, elem_vs1, elem_alu_op, elem_we, 3 + k, 4 + k);
            end
            cyc();
        end
        n_tests++;
        if ({done, issue_ready, elem_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_done: done/ready/valid=%b required 100", {done, issue_ready, elem_valid});
        end
        cyc();
        n_tests++;
        if ({done, issue_ready, elem_valid, stall} !== 4'b0100) begin
            n_fail++;
            $display("FAIL b2b_idle: done/ready/valid/stall=%b required 0100", {done, issue_ready, elem_valid, stall});
        end
        cyc();
        issue_valid = 1'b0;
        n_tests++;
        if ({elem_valid, elem_vd, elem_vs1, elem_vs2, elem_alu_op, elem_we, elem_idx} !==
            {1'b1, RW'(20), RW'(21), RW'(22), 2'b11, 1'b1, IW'(0)}) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%0b vd=%0d vs1=%0d vs2=%0d op=%0d we=%0b idx=%0d required 1 20 21 22 3 1 0",
                     elem_valid, elem_vd, elem_vs1, elem_vs2, elem_alu_op, elem_we, elem_idx);
        end
        drain();
    endtask

    task automatic test_random();
        op_t got;
        bit  exp_v;
        bit  exp_stall;
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            flush = 1'b0;
            #1;
            exp_v     = (m_ops.size() > 0);
            exp_stall = exp_v || m_done_due;
            n_tests++;
            if ({elem_valid, stall, done, issue_ready} !== {exp_v, exp_stall, m_done_due, !exp_stall}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: valid/stall/done/ready=%b required %b", c,
                         {elem_valid, stall, done, issue_ready}, {exp_v, exp_stall, m_done_due, !exp_stall});
            end
            if (exp_v) begin
                got = '{elem_idx, elem_vs1, elem_vs2, elem_vd, elem_alu_op, elem_we};
                n_tests++;
                if (got !== m_ops[0] || elem_last !== (m_ops[0].idx == IW'(N - 1))) begin
                    n_fail++;
                    $display("FAIL rand_elem[%0d]: got %h last=%0b required %h", c, got, elem_last, m_ops[0]);
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            elem_ready  = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            alu_op      = 2'($urandom);
            reg_write   = 1'($urandom);
            vs1         = RW'($urandom);
            vs2         = RW'($urandom);
            vd          = RW'($urandom);
            model_edge();
            cyc();
        end
        idle_inputs();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_ELEMS, default 4, meaning the number of element operations issued per vector instruction (legal range 2..16).
REQ-002 The module SHALL have parameter REG_IDX_W, default 5, meaning the register-index width.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The module SHALL have port issue_valid, input, width 1: a decoded instruction with is_vector=1 is offered.
REQ-006 The module SHALL have port issue_ready, output, width 1: the sequencer accepts the offered instruction.
REQ-007 The module SHALL have port alu_op, input, width 2: the decoded ALU class, captured on accept.
REQ-008 The module SHALL have port reg_write, input, width 1: the decoded write-back enable, captured on accept.
REQ-009 The module SHALL have ports vs1, vs2 and vd, input, width REG_IDX_W each: the source and destination base registers, captured on accept.
REQ-010 The module SHALL have port flush, input, width 1: synchronous abort of the current instruction.
REQ-011 The module SHALL have port elem_valid, output, width 1: an element operation is presented.
REQ-012 The module SHALL have port elem_ready, input, width 1: the lane ALU consumes the element operation.
REQ-013 The module SHALL have port elem_idx, output, width clog2(NUM_ELEMS): the current element index.
REQ-014 The module SHALL have ports elem_alu_op (width 2) and elem_we (width 1), output: the captured alu_op and reg_write.
REQ-015 The module SHALL have ports elem_vs1, elem_vs2 and elem_vd, output, width REG_IDX_W each: the captured base register plus elem_idx, modulo 2^REG_IDX_W.
REQ-016 The module SHALL have port elem_last, output, width 1: elem_idx == NUM_ELEMS-1.
REQ-017 The module SHALL have port stall, output, width 1: freezes the upstream pipeline while the sequencer is busy.
REQ-018 The module SHALL have port done, output, width 1: one-cycle pulse after the last element is consumed.

Function
REQ-019 The module SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-020 In IDLE, issue_ready SHALL be 1; when issue_valid=1, all fields SHALL be captured, elem_idx set to 0, and the FSM SHALL go to RUN.
REQ-021 In RUN, elem_valid SHALL be 1 and issue_ready SHALL be 0.
REQ-022 In RUN, when elem_valid and elem_ready are both 1, elem_idx SHALL increment; when this occurs with elem_last=1, the FSM SHALL go to DONE.
REQ-023 In RUN, while elem_ready=0, every elem_* output SHALL hold stable with no change.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE; issue_ready SHALL be 0 in DONE, so back-to-back instructions have a one-cycle bubble.
REQ-025 stall SHALL equal 1 in RUN and DONE, and 0 in IDLE.
REQ-026 Latency from accept to done SHALL be NUM_ELEMS+1 cycles when elem_ready is held at 1.
REQ-027 When flush=1 in any state, the FSM SHALL go to IDLE on the next edge, elem_idx SHALL clear, done SHALL not pulse, and an issue offered in that cycle SHALL be ignored.
REQ-028 Register-index wrap SHALL be modular, with no error or saturation (e.g. vd=30, elem_idx=3 gives elem_vd=1).
REQ-029 issue_valid SHALL be ignored outside IDLE.
REQ-030 elem_alu_op and elem_we SHALL be driven from captured registers, never directly from the inputs.

Reset
REQ-031 When rst_n=0, the FSM SHALL immediately go to IDLE, regardless of clk.
REQ-032 During reset, elem_idx and all captured fields SHALL be 0, elem_valid=0, done=0, stall=0 and issue_ready=1.
REQ-033 A reset asserted mid-RUN SHALL abandon the instruction without a done pulse.
REQ-034 After rst_n deasserts, the first accept SHALL be possible on the next rising edge.

Structure
REQ-035 The FSM state encoding, the OPCODE_VECTOR constant (7'b0100111) and the alu_op encodings SHALL reside in the shared processor package used by the control decoder.
REQ-036 Index arithmetic SHALL be inline; the design SHALL contain no sub-module other than an optional elem_counter, which SHALL contain only the index counter and the last-element compare.

Verification
REQ-037 A bench SHALL drive NUM_ELEMS=4, vs1=2, vs2=8, vd=16, elem_ready=1 and check elem_vd = 16,17,18,19 on consecutive cycles, elem_last only on the fourth, and done 5 cycles after accept.
REQ-038 A bench SHALL toggle elem_ready 1,0,0,1,1,0,1 and check elem_idx holds during the 0 cycles, all outputs stay stable, and exactly 4 handshakes occur before done.
REQ-039 A bench SHALL drive vd=30, vs1=31 and check elem_vd = 30,31,0,1 and elem_vs1 = 31,0,1,2.
REQ-040 A bench SHALL assert flush at elem_idx=2 and check IDLE the next cycle, no done, stall=0, and that a new issue is accepted on the following cycle.
REQ-041 A bench SHALL drop rst_n asynchronously between edges in RUN and check elem_valid=0 and stall=0 immediately, with no done pulse.
REQ-042 A bench SHALL hold issue_valid=1 continuously for two instructions and check a one-cycle bubble in DONE and the second instruction's fields captured only in IDLE.
